// File: rtl/blink_code_pkg.sv
// blink_code_pkg
// Shared definitions for the blink code sequencer:
//   - 2-bit state encoding of the blink engine (IDLE, ON, OFF, GAP)
//   - cnt_width(): phase counter width able to hold the longest phase
//   - id_width():  width of a source index for a given source count
package blink_code_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // The counter is loaded with duration-1, so the widest value it must hold is
  // max-1; sizing for max+1 keeps a margin and matches the documented formula.
  function automatic int cnt_width(input int on_c, input int off_c, input int gap_c);
    int m;
    m = on_c;
    if (off_c > m) m = off_c;
    if (gap_c > m) m = gap_c;
    return $clog2(m + 1);
  endfunction

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin first-one finder.
//   req   : request vector, one bit per source
//   ptr   : index served last; the search starts at ptr+1 and wraps modulo N
//   valid : at least one request is set
//   idx   : first set request found in search order (ptr when none)
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] pos;

  // Walk N positions starting just after ptr; the first hit is kept.
  always_comb begin
    pos   = ptr;
    valid = 1'b0;
    idx   = ptr;
    for (int i = 0; i < N; i++) begin
      pos = (pos == IDW'(N - 1)) ? '0 : pos + 1'b1;
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/blink_code_sequencer.sv
// blink_code_sequencer
// Shares one status LED between NUM_EVENTS sources. Each rising edge on a
// source latches a pending request; a round-robin scheduler shows one request
// at a time as a blink code (source k -> k+1 pulses, then a dark gap).
// Ports:
//   clk_i        system clock
//   reset_n_i    synchronous active-low reset
//   event_i      asynchronous event levels, rising edges counted
//   enable_i     high permits new codes to be granted
//   led_o        registered LED drive
//   busy_o       a code is in progress
//   active_id_o  index of the code in progress (held while idle)
//   pending_o    latched, not-yet-served requests
//   dropped_o    one-clock pulse when an edge hits an already pending source
module blink_code_sequencer
  import blink_code_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 50000000,
  parameter int NUM_EVENTS   = 4,
  parameter int ON_CYCLES    = SYSTEM_CLOCK / 8,
  parameter int OFF_CYCLES   = SYSTEM_CLOCK / 8,
  parameter int GAP_CYCLES   = SYSTEM_CLOCK / 2
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [NUM_EVENTS-1:0]         event_i,
  input  logic                          enable_i,
  output logic                          led_o,
  output logic                          busy_o,
  output logic [$clog2(NUM_EVENTS)-1:0] active_id_o,
  output logic [NUM_EVENTS-1:0]         pending_o,
  output logic                          dropped_o
);

  localparam int IDW = id_width(NUM_EVENTS);
  localparam int CW  = cnt_width(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
  localparam int BW  = IDW + 1;

  localparam logic [CW-1:0] ON_LD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LD = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

  logic [NUM_EVENTS-1:0] sync_p0, sync_p1, sync_p2;
  logic [NUM_EVENTS-1:0] rise, clr;
  logic [1:0]            state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         blinks_left;
  logic [IDW-1:0]        ptr, pick_idx;
  logic                  pick_vld, grant, phase_done, led_d;

  // Stages p0/p1: two-flop synchroniser. Stage p2: edge register.
  // Left out of reset so a level already high at reset release is no edge.
  always_ff @(posedge clk_i) begin
    sync_p0 <= event_i;
    sync_p1 <= sync_p0;
    sync_p2 <= sync_p1;
  end

  assign rise = sync_p1 & ~sync_p2;

  rr_pick #(
    .N   (NUM_EVENTS),
    .IDW (IDW)
  ) u_pick (
    .req   (pending_o),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign phase_done = (cnt == '0);
  assign busy_o     = (state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_i && pick_vld) begin
          grant     = 1'b1;
          state_nxt = ST_ON;
        end
      end
      ST_ON:   if (phase_done) state_nxt = (blinks_left == BW'(1)) ? ST_GAP : ST_OFF;
      ST_OFF:  if (phase_done) state_nxt = ST_ON;
      default: if (phase_done) state_nxt = ST_IDLE;
    endcase
  end

  // LED is registered from the next state so it lines up with the state flop.
  always_comb begin
    led_d = (state_nxt == ST_ON);
  end

  always_comb begin
    clr = '0;
    if (grant) clr[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      led_o       <= 1'b0;
      pending_o   <= '0;
      dropped_o   <= 1'b0;
      ptr         <= IDW'(NUM_EVENTS - 1);
      active_id_o <= '0;
      cnt         <= '0;
      blinks_left <= '0;
    end else begin
      led_o <= led_d;
      // A fresh edge on the id being granted re-arms it rather than dropping.
      pending_o <= (pending_o & ~clr) | rise;
      dropped_o <= |(rise & pending_o & ~clr);
      if (grant) begin
        ptr         <= pick_idx;
        active_id_o <= pick_idx;
        blinks_left <= {1'b0, pick_idx} + 1'b1;
      end else if (state == ST_ON && phase_done) begin
        blinks_left <= blinks_left - 1'b1;
      end
      // Load duration-1 on every phase entry, then count down to zero.
      if (state_nxt != state) begin
        case (state_nxt)
          ST_ON:   cnt <= ON_LD;
          ST_OFF:  cnt <= OFF_LD;
          ST_GAP:  cnt <= GAP_LD;
          default: cnt <= '0;
        endcase
      end else if (!phase_done) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_blink_code_sequencer.sv
// tb_blink_code_sequencer
// Scoreboard bench: a reference model predicts each blink code at grant time
// and queues it; a monitor captures each busy window from the DUT and compares
// id, length and LED pattern. Pending/dropped/busy are compared every cycle.
module tb_blink_code_sequencer;

  localparam int N   = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int GAP = 5;

  logic         clk = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         enable_i = 1'b0;
  logic [N-1:0] event_i = '0;
  logic         led_o, busy_o, dropped_o;
  logic [1:0]   active_id_o;
  logic [N-1:0] pending_o;

  blink_code_sequencer #(
    .SYSTEM_CLOCK (1000),
    .NUM_EVENTS   (N),
    .ON_CYCLES    (ON),
    .OFF_CYCLES   (OFF),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .event_i     (event_i),
    .enable_i    (enable_i),
    .led_o       (led_o),
    .busy_o      (busy_o),
    .active_id_o (active_id_o),
    .pending_o   (pending_o),
    .dropped_o   (dropped_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    int          len;
    logic [31:0] pat;
  } code_t;

  code_t exp_q[$];

  // Reference model state
  int           cyc = 0;
  logic [N-1:0] h0 = '0, h1 = '0, h2 = '0;
  logic [N-1:0] m_pend = '0;
  int           m_ptr = N - 1;
  int           m_free = 0;
  int           m_busy_end = 0;
  logic [N-1:0] exp_pend = '0;
  logic         exp_drop = 1'b0;
  logic         exp_busy = 1'b0;
  logic         rst_seen = 1'b1;

  // Monitor state
  bit           cap = 1'b0;
  int           cid = 0;
  int           clen = 0;
  logic [31:0]  cpat = '0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Model: event edge seen two samples back sets pending at this edge; a grant
  // happens when the engine is free, enable is high and something is pending.
  always @(posedge clk) begin : model
    logic [N-1:0] rise, clr;
    int id, p, pos;
    code_t c;
    cyc++;
    rise = h1 & ~h2;
    h2 = h1;
    h1 = h0;
    h0 = event_i;
    rst_seen = !reset_n_i;
    if (!reset_n_i) begin
      m_pend     = '0;
      m_ptr      = N - 1;
      m_free     = 0;
      m_busy_end = 0;
      exp_drop   = 1'b0;
      exp_q.delete();
    end else begin
      clr = '0;
      if (cyc >= m_free && enable_i && m_pend != '0) begin
        id = -1;
        for (int k = 1; k <= N; k++) begin
          p = (m_ptr + k) % N;
          if (id < 0 && m_pend[p[1:0]]) id = p;
        end
        m_ptr = id;
        clr[id[1:0]] = 1'b1;
        c.id  = id;
        c.pat = '0;
        pos   = 0;
        for (int b = 0; b <= id; b++) begin
          for (int j = 0; j < ON; j++) begin
            c.pat[pos[4:0]] = 1'b1;
            pos++;
          end
          if (b < id) pos += OFF;
        end
        pos += GAP;
        c.len = pos;
        exp_q.push_back(c);
        m_busy_end = cyc + pos;
        m_free     = cyc + pos + 1;
      end
      exp_drop = |(rise & m_pend & ~clr);
      m_pend   = (m_pend & ~clr) | rise;
    end
    exp_pend = m_pend;
    exp_busy = (cyc < m_busy_end);
  end

  always @(negedge clk) begin : monitor
    code_t e;
    if (rst_seen) begin
      cap = 1'b0;
      chk("rst_led",  int'(led_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_pend", int'(pending_o), 0);
      chk("rst_drop", int'(dropped_o), 0);
      chk("rst_id",   int'(active_id_o), 0);
    end else begin
      chk("pending", int'(pending_o), int'(exp_pend));
      chk("dropped", int'(dropped_o), int'(exp_drop));
      chk("busy",    int'(busy_o), int'(exp_busy));
      if (busy_o && !cap) begin
        cap  = 1'b1;
        cid  = int'(active_id_o);
        clen = 0;
        cpat = '0;
      end
      if (cap && busy_o) begin
        if (clen < 32) cpat[clen[4:0]] = led_o;
        clen++;
      end else if (!busy_o) begin
        chk("idle_led", int'(led_o), 0);
        if (cap) begin
          cap = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_code", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("code_id",  cid, e.id);
            chk("code_len", clen, e.len);
            chk("code_pat", int'(cpat), int'(e.pat));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    event_i = event_i | m;
    tick(1);
    event_i = event_i & ~m;
  endtask

  initial begin
    int w;
    logic [N-1:0] flip;
    reset_n_i = 1'b0;
    enable_i  = 1'b1;
    event_i   = '0;
    tick(6);
    reset_n_i = 1'b1;
    tick(2);

    // Single edge on source 2
    pulse(4'b0100);
    tick(30);

    // Sources 0, 1 and 3 together
    pulse(4'b1011);
    tick(90);

    // Source 1 re-triggers while pending and the engine serves 0
    pulse(4'b0011);
    tick(5);
    pulse(4'b0010);
    tick(40);

    // Grants blocked while disabled
    enable_i = 1'b0;
    pulse(4'b0101);
    tick(12);
    enable_i = 1'b1;
    tick(40);

    // Reset during the second ON of id 2, then a fresh edge on 3
    pulse(4'b0100);
    tick(8);
    reset_n_i = 1'b0;
    tick(1);
    reset_n_i = 1'b1;
    tick(3);
    pulse(4'b1000);
    tick(40);

    // Sources 0 and 1 re-triggering continuously
    for (int i = 0; i < 150; i++) begin
      event_i[1:0] = i[0] ? 2'b11 : 2'b00;
      tick(1);
    end
    event_i = '0;
    tick(60);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      flip = '0;
      for (int k = 0; k < N; k++) flip[k] = ($urandom_range(7) == 0);
      event_i   = event_i ^ flip;
      enable_i  = ($urandom_range(7) != 0);
      reset_n_i = ($urandom_range(499) != 0);
      tick(1);
    end
    event_i   = '0;
    enable_i  = 1'b1;
    reset_n_i = 1'b1;

    w = 0;
    while ((busy_o || exp_q.size() != 0 || pending_o != '0) && w < 500) begin
      tick(1);
      w++;
    end
    chk("drain_done", int'(w < 500), 1);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
